rot_cmd_sequencer: RTL and testbench
====================================

Name: rot_cmd_sequencer

Overview:
Upstream command sequencer for the 100-bit left/right rotator stage. It accepts one command per handshake (load word, rotate right N, rotate left N, no-op) and expands it into the rotator's cycle-by-cycle controls: a one-cycle load pulse or N consecutive ena cycles. It sits between the control/bus logic and the rotator's clk/load/ena/data inputs, and it reports completion back upstream.

Parameters:
WIDTH, 100, rotator word width; also the data port width.
CNT_W, 7, step-count width. Constraint: 2**CNT_W - 1 < 2*WIDTH.

Ports:
clk  in  1  rising-edge clock, shared with the rotator
areset  in  1  asynchronous, active-high reset
cmd_valid  in  1  a command is presented this cycle
cmd_ready  out  1  the sequencer can accept a command
cmd_op  in  2  00 LOAD, 01 ROT_R, 10 ROT_L, 11 NOP
cmd_count  in  CNT_W  number of rotate steps (ignored for LOAD and NOP)
cmd_data  in  WIDTH  word to load (LOAD only)
abort  in  1  synchronous request to stop an in-progress rotate
load  out  1  rotator load strobe
ena  out  2  rotator enable: 01 = shift toward bit 0 (bit0 wraps to bit WIDTH-1), 10 = shift toward MSB, 00 = hold
data  out  WIDTH  rotator load data
busy  out  1  a command is executing
done  out  1  one-cycle completion pulse
aborted  out  1  qualifies done: the last command was aborted
steps_left  out  CNT_W  remaining rotate steps (debug)

Behaviour:
- Reset (async assert, any state):
  - state = IDLE.
  - load = 0, ena = 00, data = 0, busy = 0, done = 0, aborted = 0, steps_left = 0.
  - cmd_ready = 1.
- All outputs except cmd_ready are registered. cmd_ready = (state == IDLE).
- Accept occurs at a rising edge with cmd_valid && cmd_ready (cycle T). Inputs are sampled only at accept. cmd_valid while not ready is ignored; no queueing.
- States:
  - IDLE
    - LOAD accept -> LOAD_ST.
    - ROT_R/ROT_L with reduced count > 0 -> ROTATE.
    - NOP, or rotate with reduced count == 0 -> DONE.
  - LOAD_ST
    - During cycle T+1: load = 1, data = cmd_data, busy = 1.
    - Next state DONE.
  - ROTATE
    - ena held at the command's code for exactly n consecutive cycles, T+1 .. T+n. busy = 1.
    - steps_left = n at T+1 and decrements each cycle.
    - After the last ena cycle -> DONE.
  - DONE
    - One cycle: done = 1, busy = 0, load = 0, ena = 00.
    - Next state IDLE.
- Count reduction: n = cmd_count if cmd_count < WIDTH, else cmd_count - WIDTH. A single subtraction suffices given the CNT_W constraint. Example: count 127 -> 27 steps; count 100 -> 0 steps.
- data holds its last loaded value outside LOAD_ST. load and ena are never asserted in the same cycle.
- Abort:
  - Sampled only in ROTATE. When abort is high at an edge, the next cycle has ena = 00 and state DONE with done = 1, aborted = 1.
  - Steps already issued stand; steps_left freezes at the remaining value.
  - Abort in IDLE, LOAD_ST or DONE is ignored.
  - Abort coinciding with the last step edge: the rotation completes normally, aborted = 0.
- aborted updates only in DONE and holds until the next DONE.
- Latency:
  - LOAD: accept to done = 2 cycles.
  - ROTATE n: accept to done = n + 1 cycles.
  - NOP or zero count: accept to done = 1 cycle.
  - Minimum command spacing = latency + 1, since ready returns in IDLE.
- Reset mid-operation: load and ena drop immediately (asynchronously); no done pulse; the command is lost.

Decomposition:
- Shared package:
  - Op codes: OP_LOAD, OP_ROT_R, OP_ROT_L, OP_NOP.
  - Enable codes: ENA_HOLD = 00, ENA_SHR = 01, ENA_SHL = 10.
  - State enum: IDLE, LOAD_ST, ROTATE, DONE.
  - Default WIDTH (100) and CNT_W (7), shared with the rotator.
- Single module; no sub-module warranted. The count reducer is inline combinational logic.

Test Plan:
- Reset, then LOAD data=100'h1 -> load=1 with data=1 in cycle T+1; done at T+2. Rotator q = 1.
- After LOAD 1, ROT_R count=1 -> ena=01 for exactly 1 cycle; rotator q = 1<<99; done at T+2.
- LOAD 100'h3, then ROT_L count=127 -> exactly 27 ena=10 cycles; q = 3<<27; steps_left counts 27 down to 1.
- ROT_L count=100 and NOP -> no ena cycles; done 1 cycle after accept; q unchanged.
- ROT_R count=50 with abort raised at step 10 -> ena=01 for 10 cycles, then done=1, aborted=1; q equals the 10-step rotation; a subsequent LOAD gives aborted=0.
- areset pulse asserted mid-ROTATE (step 5 of 40) -> ena=00 immediately, cmd_ready=1, no done pulse; the next command is accepted normally.

Source files
------------

// File: rtl/rot_cmd_sequencer_pkg.sv
// Shared definitions for the rotator command sequencer and the 100-bit rotator it drives.
package rot_cmd_sequencer_pkg;

    localparam int unsigned ROT_WIDTH = 100;
    localparam int unsigned ROT_CNT_W = 7;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_ROT_R = 2'b01,
        OP_ROT_L = 2'b10,
        OP_NOP   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ENA_HOLD = 2'b00,
        ENA_SHR  = 2'b01,
        ENA_SHL  = 2'b10
    } ena_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        LOAD_ST = 2'b01,
        ROTATE  = 2'b10,
        DONE    = 2'b11
    } state_e;

endpackage

// File: rtl/rot_cmd_sequencer.sv
// Expands handshaked commands into rotator load/ena cycles and reports completion.
module rot_cmd_sequencer
    import rot_cmd_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = ROT_WIDTH,
    parameter int unsigned CNT_W = ROT_CNT_W
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             abort,
    output logic             load,
    output logic [1:0]       ena,
    output logic [WIDTH-1:0] data,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] steps_left
);

    state_e           r_state;
    logic             r_load;
    logic [1:0]       r_ena;
    logic [WIDTH-1:0] r_data;
    logic             r_busy;
    logic             r_done;
    logic             r_aborted;
    logic [CNT_W-1:0] r_steps_left;

    state_e           w_state_nxt;
    logic             w_load_nxt;
    logic [1:0]       w_ena_nxt;
    logic [WIDTH-1:0] w_data_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_aborted_nxt;
    logic [CNT_W-1:0] w_steps_nxt;
    logic [CNT_W-1:0] w_cnt_red;

    // Counts of WIDTH or more wrap once; CNT_W guarantees one subtraction is enough.
    assign w_cnt_red = (cmd_count < CNT_W'(WIDTH)) ? cmd_count
                                                   : cmd_count - CNT_W'(WIDTH);

    assign cmd_ready  = (r_state == IDLE);
    assign load       = r_load;
    assign ena        = r_ena;
    assign data       = r_data;
    assign busy       = r_busy;
    assign done       = r_done;
    assign aborted    = r_aborted;
    assign steps_left = r_steps_left;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state      <= IDLE;
            r_load       <= 1'b0;
            r_ena        <= ENA_HOLD;
            r_data       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_steps_left <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_load       <= w_load_nxt;
            r_ena        <= w_ena_nxt;
            r_data       <= w_data_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_aborted    <= w_aborted_nxt;
            r_steps_left <= w_steps_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_load_nxt    = 1'b0;
        w_ena_nxt     = ENA_HOLD;
        w_data_nxt    = r_data;
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        w_aborted_nxt = r_aborted;
        w_steps_nxt   = r_steps_left;

        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_LOAD: begin
                            w_state_nxt = LOAD_ST;
                            w_load_nxt  = 1'b1;
                            w_data_nxt  = cmd_data;
                            w_busy_nxt  = 1'b1;
                        end
                        OP_ROT_R, OP_ROT_L: begin
                            if (w_cnt_red != '0) begin
                                w_state_nxt = ROTATE;
                                w_ena_nxt   = (cmd_op == OP_ROT_R) ? ENA_SHR : ENA_SHL;
                                w_busy_nxt  = 1'b1;
                                w_steps_nxt = w_cnt_red;
                            end else begin
                                w_state_nxt   = DONE;
                                w_done_nxt    = 1'b1;
                                w_aborted_nxt = 1'b0;
                                w_steps_nxt   = '0;
                            end
                        end
                        default: begin
                            w_state_nxt   = DONE;
                            w_done_nxt    = 1'b1;
                            w_aborted_nxt = 1'b0;
                            w_steps_nxt   = '0;
                        end
                    endcase
                end
            end
            LOAD_ST: begin
                w_state_nxt   = DONE;
                w_done_nxt    = 1'b1;
                w_aborted_nxt = 1'b0;
            end
            ROTATE: begin
                // The final step wins over a coincident abort.
                if (r_steps_left == CNT_W'(1)) begin
                    w_state_nxt   = DONE;
                    w_done_nxt    = 1'b1;
                    w_aborted_nxt = 1'b0;
                    w_steps_nxt   = '0;
                end else if (abort) begin
                    w_state_nxt   = DONE;
                    w_done_nxt    = 1'b1;
                    w_aborted_nxt = 1'b1;
                    w_steps_nxt   = r_steps_left - CNT_W'(1);
                end else begin
                    w_ena_nxt   = r_ena;
                    w_busy_nxt  = 1'b1;
                    w_steps_nxt = r_steps_left - CNT_W'(1);
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rot_cmd_sequencer.sv
// Directed bench for rot_cmd_sequencer driving a behavioural 100-bit rotator.
module tb_rot_cmd_sequencer;
    import rot_cmd_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = OP_NOP;
    logic [6:0]  cmd_count = '0;
    logic [99:0] cmd_data = '0;
    logic        abort = 1'b0;
    logic        load;
    logic [1:0]  ena;
    logic [99:0] data;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [6:0]  steps_left;
    logic [99:0] q;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    rot_cmd_sequencer dut (
        .clk        (clk),
        .areset     (areset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_count  (cmd_count),
        .cmd_data   (cmd_data),
        .abort      (abort),
        .load       (load),
        .ena        (ena),
        .data       (data),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .steps_left (steps_left)
    );

    // Reference rotator fed by the sequencer outputs
    always @(posedge clk) begin
        if (load)              q <= data;
        else if (ena == 2'b01) q <= {q[0], q[99:1]};
        else if (ena == 2'b10) q <= {q[98:0], q[99]};
    end

    // Present a command for one cycle; returns at the negedge of cycle T+1.
    task automatic issue(input logic [1:0] op, input logic [6:0] cnt, input logic [99:0] d);
        cmd_valid = 1'b1; cmd_op = op; cmd_count = cnt; cmd_data = d;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_count = 7'h55; cmd_data = ~d;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", cmd_ready); else n_pass++;
        n_checks++; if ({load, ena, busy, done, aborted} !== 6'b0) $display("FAIL reset_ctl: got %b want 000000", {load, ena, busy, done, aborted}); else n_pass++;
        n_checks++; if (data !== 100'h0) $display("FAIL reset_data: got %h want 0", data); else n_pass++;
        n_checks++; if (steps_left !== 7'd0) $display("FAIL reset_steps: got %0d want 0", steps_left); else n_pass++;
        areset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load();
        issue(OP_LOAD, 7'd0, 100'h1);
        n_checks++; if (load !== 1'b1) $display("FAIL load_pulse: got %b want 1", load); else n_pass++;
        n_checks++; if (data !== 100'h1) $display("FAIL load_data: got %h want 1", data); else n_pass++;
        n_checks++; if ({busy, cmd_ready, ena} !== 4'b1000) $display("FAIL load_busy: got %b want 1000", {busy, cmd_ready, ena}); else n_pass++;
        @(negedge clk);
        n_checks++; if ({done, load, aborted, busy} !== 4'b1000) $display("FAIL load_done: got %b want 1000", {done, load, aborted, busy}); else n_pass++;
        n_checks++; if (q !== 100'h1) $display("FAIL load_q: got %h want 1", q); else n_pass++;
        @(negedge clk);
        n_checks++; if ({done, cmd_ready} !== 2'b01) $display("FAIL load_idle: got %b want 01", {done, cmd_ready}); else n_pass++;
    endtask

    task automatic test_rot_r1();
        logic [99:0] exp_q;
        exp_q = 100'h1 << 99;
        issue(OP_ROT_R, 7'd1, 100'h0);
        n_checks++; if ({ena, busy, load} !== 4'b0110) $display("FAIL rotr1_ena: got %b want 0110", {ena, busy, load}); else n_pass++;
        n_checks++; if (steps_left !== 7'd1) $display("FAIL rotr1_steps: got %0d want 1", steps_left); else n_pass++;
        @(negedge clk);
        n_checks++; if ({ena, done} !== 3'b001) $display("FAIL rotr1_done: got %b want 001", {ena, done}); else n_pass++;
        n_checks++; if (q !== exp_q) $display("FAIL rotr1_q: got %h want %h", q, exp_q); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_rot_l_wrap();
        int k;
        int bad;
        logic [99:0] exp_q;
        exp_q = 100'h3 << 27;
        issue(OP_LOAD, 7'd0, 100'h3);
        repeat (2) @(negedge clk);
        issue(OP_ROT_L, 7'd127, 100'h0);
        k = 0; bad = 0;
        while (ena == 2'b10 && k < 200) begin
            if (steps_left !== 7'(27 - k)) bad++;
            k++;
            @(negedge clk);
        end
        n_checks++; if (k !== 27) $display("FAIL rotl127_cycles: got %0d want 27", k); else n_pass++;
        n_checks++; if (bad !== 0) $display("FAIL rotl127_countdown: got %0d bad steps want 0", bad); else n_pass++;
        n_checks++; if ({done, busy} !== 2'b10) $display("FAIL rotl127_done: got %b want 10", {done, busy}); else n_pass++;
        n_checks++; if (q !== exp_q) $display("FAIL rotl127_q: got %h want %h", q, exp_q); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_zero_and_nop();
        logic [99:0] exp_q;
        exp_q = 100'h3 << 27;
        issue(OP_ROT_L, 7'd100, 100'h0);
        n_checks++; if ({done, ena, busy, cmd_ready} !== 5'b10000) $display("FAIL zero_done: got %b want 10000", {done, ena, busy, cmd_ready}); else n_pass++;
        @(negedge clk);
        n_checks++; if (q !== exp_q) $display("FAIL zero_q: got %h want %h", q, exp_q); else n_pass++;
        n_checks++; if ({done, cmd_ready} !== 2'b01) $display("FAIL zero_idle: got %b want 01", {done, cmd_ready}); else n_pass++;
        issue(OP_NOP, 7'd5, 100'h0);
        n_checks++; if ({done, ena, load} !== 4'b1000) $display("FAIL nop_done: got %b want 1000", {done, ena, load}); else n_pass++;
        @(negedge clk);
        n_checks++; if (q !== exp_q) $display("FAIL nop_q: got %h want %h", q, exp_q); else n_pass++;
    endtask

    task automatic test_abort();
        int k;
        logic [99:0] exp_q;
        exp_q = 100'h1 << 90;
        abort = 1'b1;
        issue(OP_LOAD, 7'd0, 100'h1);
        abort = 1'b0;
        repeat (2) @(negedge clk);
        issue(OP_ROT_R, 7'd50, 100'h0);
        k = 0;
        while (ena == 2'b01 && k < 100) begin
            k++;
            if (k == 10) abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
        n_checks++; if (k !== 10) $display("FAIL abort_cycles: got %0d want 10", k); else n_pass++;
        n_checks++; if ({done, aborted, ena} !== 4'b1100) $display("FAIL abort_flags: got %b want 1100", {done, aborted, ena}); else n_pass++;
        n_checks++; if (q !== exp_q) $display("FAIL abort_q: got %h want %h", q, exp_q); else n_pass++;
        @(negedge clk);
        n_checks++; if ({aborted, cmd_ready} !== 2'b11) $display("FAIL abort_hold: got %b want 11", {aborted, cmd_ready}); else n_pass++;
        issue(OP_LOAD, 7'd0, 100'h5);
        @(negedge clk);
        n_checks++; if ({done, aborted} !== 2'b10) $display("FAIL abort_clear: got %b want 10", {done, aborted}); else n_pass++;
        @(negedge clk);
        // Abort on the final step edge must not flag the command as aborted.
        issue(OP_ROT_R, 7'd2, 100'h0);
        k = 0;
        while (ena == 2'b01 && k < 100) begin
            k++;
            if (k == 2) abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
        n_checks++; if (k !== 2) $display("FAIL abort_last_cycles: got %0d want 2", k); else n_pass++;
        n_checks++; if ({done, aborted} !== 2'b10) $display("FAIL abort_last_flags: got %b want 10", {done, aborted}); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int seen;
        issue(OP_ROT_R, 7'd40, 100'h0);
        repeat (4) @(negedge clk);
        n_checks++; if ({ena, steps_left} !== {2'b01, 7'd36}) $display("FAIL mid_step5: got %b/%0d want 01/36", ena, steps_left); else n_pass++;
        #1 areset = 1'b1;
        #1;
        n_checks++; if ({ena, load, busy, cmd_ready} !== 5'b00001) $display("FAIL mid_async: got %b want 00001", {ena, load, busy, cmd_ready}); else n_pass++;
        @(negedge clk);
        areset = 1'b0;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) seen++;
        end
        n_checks++; if (seen !== 0) $display("FAIL mid_no_done: got %0d pulses want 0", seen); else n_pass++;
        issue(OP_NOP, 7'd0, 100'h0);
        n_checks++; if ({done, aborted} !== 2'b10) $display("FAIL mid_next_cmd: got %b want 10", {done, aborted}); else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load();
        test_rot_r1();
        test_rot_l_wrap();
        test_zero_and_nop();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
